// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// The slave modport is the adder side; master is the driver side.
interface full_adder_if;
    logic [1:0] bits;
    logic       carryIn;
    logic       in_valid;
    logic       result;
    logic       carryOut;
    logic       out_valid;

    modport master (
        output bits, carryIn, in_valid,
        input  result, carryOut, out_valid
    );

    modport slave (
        input  bits, carryIn, in_valid,
        output result, carryOut, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered 1-bit full adder with LATENCY pipeline stages and a travelling valid flag.
// Define FULL_ADDER_CARRY_STATS_EN to add the saturating carry_count output.
module full_adder #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    full_adder_if.slave     fa_bus
`ifdef FULL_ADDER_CARRY_STATS_EN
    ,
    output logic [CNT_W-1:0] carry_count
`endif
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("full_adder: LATENCY must be in 1..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("full_adder: CNT_W must be at least 1");
    end

    typedef struct packed {
        logic valid;
        logic carry;
        logic sum;
    } stage_t;

    stage_t                  w_stage_in;
    stage_t [LATENCY-1:0]    r_pipe;

    always_comb begin
        w_stage_in.valid = fa_bus.in_valid;
        w_stage_in.sum   = fa_bus.bits[0] ^ fa_bus.bits[1] ^ fa_bus.carryIn;
        w_stage_in.carry = (fa_bus.bits[0] & fa_bus.bits[1])
                         | (fa_bus.bits[0] & fa_bus.carryIn)
                         | (fa_bus.bits[1] & fa_bus.carryIn);
    end

    // Stage 0 captures the new sample; higher stages shift unconditionally.
    if (LATENCY == 1) begin : g_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= w_stage_in;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[LATENCY-2:0], w_stage_in};
            end
        end
    end

    assign fa_bus.result    = r_pipe[LATENCY-1].sum;
    assign fa_bus.carryOut  = r_pipe[LATENCY-1].carry;
    assign fa_bus.out_valid = r_pipe[LATENCY-1].valid;

`ifdef FULL_ADDER_CARRY_STATS_EN
    logic [CNT_W-1:0] r_carry_count;

    // Counts from the registered outputs, so it trails carryOut by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_count <= '0;
        end else if (r_pipe[LATENCY-1].valid && r_pipe[LATENCY-1].carry
                     && (r_carry_count != '1)) begin
            r_carry_count <= r_carry_count + CNT_W'(1);
        end
    end

    assign carry_count = r_carry_count;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at LATENCY 1, 3 and 4.
// Carry-statistics checks run only when FULL_ADDER_CARRY_STATS_EN is defined.
module tb_full_adder;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst1, rst3, rst4;

    full_adder_if if1 ();
    full_adder_if if3 ();
    full_adder_if if4 ();

`ifdef FULL_ADDER_CARRY_STATS_EN
    logic [1:0]  cc1;
    logic [15:0] cc3, cc4;
`endif

    full_adder #(.LATENCY(1), .CNT_W(2)) u_lat1 (
        .clk(clk), .rst(rst1), .fa_bus(if1)
`ifdef FULL_ADDER_CARRY_STATS_EN
        , .carry_count(cc1)
`endif
    );

    full_adder #(.LATENCY(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst3), .fa_bus(if3)
`ifdef FULL_ADDER_CARRY_STATS_EN
        , .carry_count(cc3)
`endif
    );

    full_adder #(.LATENCY(4), .CNT_W(16)) u_lat4 (
        .clk(clk), .rst(rst4), .fa_bus(if4)
`ifdef FULL_ADDER_CARRY_STATS_EN
        , .carry_count(cc4)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic a, input logic b, input logic c, input logic v);
        if1.bits = {b, a}; if1.carryIn = c; if1.in_valid = v;
    endtask

    task automatic drv3(input logic a, input logic b, input logic c, input logic v);
        if3.bits = {b, a}; if3.carryIn = c; if3.in_valid = v;
    endtask

    task automatic drv4(input logic a, input logic b, input logic c, input logic v);
        if4.bits = {b, a}; if4.carryIn = c; if4.in_valid = v;
    endtask

    // {A, B, Cin, result, carryOut}
    logic [4:0] tt [8] = '{5'b000_00, 5'b010_10, 5'b100_10, 5'b110_01,
                           5'b001_10, 5'b011_01, 5'b101_01, 5'b111_11};
    // {A, B, Cin, in_valid, result, carryOut}
    logic [5:0] gv [3] = '{6'b011_1_01, 6'b111_0_00, 6'b100_1_10};
    // LATENCY=4 stream {A, B, Cin} and expected {result, carryOut}
    logic [2:0] s4_in  [3] = '{3'b111, 3'b000, 3'b110};
    logic [1:0] s4_exp [3] = '{2'b11, 2'b00, 2'b01};

    initial begin
        logic [4:0] v;
        logic [5:0] g;
        logic [2:0] s;
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        drv1(1'b0, 1'b0, 1'b0, 1'b0);
        drv3(1'b0, 1'b0, 1'b0, 1'b0);
        drv4(1'b0, 1'b0, 1'b0, 1'b0);

        #5;
        check("rst_result",    {15'd0, if1.result},    16'd0);
        check("rst_carryOut",  {15'd0, if1.carryOut},  16'd0);
        check("rst_out_valid", {15'd0, if1.out_valid}, 16'd0);
        check("rst_l4_valid",  {15'd0, if4.out_valid}, 16'd0);

        // Exhaustive truth table, LATENCY=1
        @(negedge clk) rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = tt[i];
            drv1(v[4], v[3], v[2], 1'b1);
            tick();
            check($sformatf("tt%0d_result", i),   {15'd0, if1.result},    {15'd0, v[1]});
            check($sformatf("tt%0d_carry", i),    {15'd0, if1.carryOut},  {15'd0, v[0]});
            check($sformatf("tt%0d_valid", i),    {15'd0, if1.out_valid}, 16'd1);
        end

        // Valid gating, LATENCY=1
        for (int i = 0; i < 3; i++) begin
            g = gv[i];
            drv1(g[5], g[4], g[3], g[2]);
            tick();
            check($sformatf("gate%0d_valid", i), {15'd0, if1.out_valid}, {15'd0, g[2]});
            if (g[2]) begin
                check($sformatf("gate%0d_result", i), {15'd0, if1.result},   {15'd0, g[1]});
                check($sformatf("gate%0d_carry", i),  {15'd0, if1.carryOut}, {15'd0, g[0]});
            end
        end

`ifdef FULL_ADDER_CARRY_STATS_EN
        // Saturating carry counter, CNT_W=2
        rst1 = 1'b1;
        #1;
        check("cc_rst", {14'd0, cc1}, 16'd0);
        @(negedge clk) rst1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            drv1(1'b1, 1'b1, 1'b1, (k < 6) ? 1'b1 : 1'b0);
            tick();
            check($sformatf("cc_k%0d", k), {14'd0, cc1}, 16'((k > 3) ? 3 : k));
        end
        rst1 = 1'b1;
        #1;
        check("cc_rst_again", {14'd0, cc1}, 16'd0);
        rst1 = 1'b0;
`endif

        // LATENCY=4 back-to-back stream; X on inputs while invalid
        @(negedge clk) rst4 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                s = s4_in[k];
                drv4(s[2], s[1], s[0], 1'b1);
            end else begin
                drv4(1'bx, 1'bx, 1'bx, 1'b0);
            end
            tick();
            check($sformatf("l4_k%0d_valid", k), {15'd0, if4.out_valid},
                  (k >= 3 && k <= 5) ? 16'd1 : 16'd0);
            if (k >= 3 && k <= 5) begin
                check($sformatf("l4_k%0d_result", k), {15'd0, if4.result},   {15'd0, s4_exp[k-3][1]});
                check($sformatf("l4_k%0d_carry", k),  {15'd0, if4.carryOut}, {15'd0, s4_exp[k-3][0]});
            end
        end

        // LATENCY=3 asynchronous reset with two samples in flight
        @(negedge clk) rst3 = 1'b0;
        drv3(1'b1, 1'b1, 1'b1, 1'b1); tick();
        drv3(1'b1, 1'b1, 1'b0, 1'b1); tick();
        drv3(1'b0, 1'b1, 1'b1, 1'b1); tick();
        check("l3_pre_valid",  {15'd0, if3.out_valid}, 16'd1);
        check("l3_pre_result", {15'd0, if3.result},    16'd1);
        check("l3_pre_carry",  {15'd0, if3.carryOut},  16'd1);
        drv3(1'b0, 1'b0, 1'b0, 1'b0);
        #4 rst3 = 1'b1;
        #1;
        check("l3_async_valid",  {15'd0, if3.out_valid}, 16'd0);
        check("l3_async_result", {15'd0, if3.result},    16'd0);
        check("l3_async_carry",  {15'd0, if3.carryOut},  16'd0);
        tick();
        check("l3_hold_valid", {15'd0, if3.out_valid}, 16'd0);
        @(negedge clk) rst3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("l3_stale%0d", k), {15'd0, if3.out_valid}, 16'd0);
        end

        // Reset release: first sample taken on the first edge with rst=0
        rst3 = 1'b1;
        @(negedge clk) rst3 = 1'b0;
        drv3(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("rel_e1_valid", {15'd0, if3.out_valid}, 16'd0);
        drv3(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rel_e2_valid", {15'd0, if3.out_valid}, 16'd0);
        tick();
        check("rel_e3_valid",  {15'd0, if3.out_valid}, 16'd1);
        check("rel_e3_result", {15'd0, if3.result},    16'd0);
        check("rel_e3_carry",  {15'd0, if3.carryOut},  16'd1);
        tick();
        check("rel_e4_valid", {15'd0, if3.out_valid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered 1-bit full adder with operand, carry-in, sum and carry-out ports named bits, carryIn, result and carryOut.
- Adds bits[0] + bits[1] + carryIn and presents result (sum) and carryOut after a configurable pipeline latency, with a valid flag travelling alongside.
- Used as the leaf cell of ripple/pipelined adder chains and as a stand-alone arithmetic sanity block.

Parameters:
- LATENCY, 1, number of register stages from input sample to output; legal 1..8; other values are a compile-time error.
- CNT_W, 16, width of the carry-event counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- bits  input  2  operands; bits[0] = A, bits[1] = B
- carryIn  input  1  carry input
- in_valid  input  1  operands valid this cycle; tie to 1 for free-running use
- result  output  1  sum bit, A XOR B XOR carryIn
- carryOut  output  1  carry bit, majority(A, B, carryIn)
- out_valid  output  1  result/carryOut correspond to a valid input sample

Behaviour:
- Arithmetic: the 2-bit value {carryOut, result} equals A + B + carryIn (range 0..3). All 8 input combinations are legal.
- Sampling: on every rising clk edge, the stage-1 registers capture the sum, the carry and in_valid. No enable is provided.
- Each further stage copies the previous stage unconditionally.
- Latency: an input applied before edge N appears on result/carryOut/out_valid after edge N+LATENCY-1. With LATENCY=1 it appears right after the sampling edge.
- Throughput: one sample per cycle, no back-pressure, no stall.
- Invalid samples: when in_valid=0 the data registers still load, but their value is don't-care.
  - Outputs are meaningful only while out_valid=1.
  - The bench checks data only when out_valid=1.
- Reset: rst=1 immediately (asynchronously) clears every pipeline stage. result=0, carryOut=0, out_valid=0 (and carry_count=0) while rst is held.
- Reset release: the first sample is taken on the first rising edge with rst=0.
- Reset mid-operation: in-flight samples are discarded, with no partial output. out_valid stays 0 until LATENCY edges after release with in_valid=1.
- Outputs are driven only from registers; no combinational path from inputs to outputs.
- X on inputs while in_valid=0 must not propagate to out_valid.

Optional Feature:
- Macro: FULL_ADDER_CARRY_STATS_EN.
- Defined: adds output port carry_count (output, CNT_W bits).
  - Increments by 1 on each clk edge where out_valid=1 and carryOut=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared asynchronously by rst.
  - Sampled from the registered outputs, so it lags carryOut by one cycle.
- Not defined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Exhaustive truth table, LATENCY=1, in_valid=1, inputs held 20 time units each:
  - (A,B,Cin) = 000→0/0, 010→1/0, 100→1/0, 110→0/1, 001→1/0, 011→0/1, 101→0/1, 111→1/1 (result/carryOut), with out_valid=1.
- LATENCY=4, back-to-back 111, 000, 110 on consecutive cycles:
  - Outputs 1/1, 0/0, 0/1 appear on cycles 4, 5, 6 after the first sample.
  - out_valid is high for exactly those 3 cycles.
- Valid gating: in_valid pattern 1,0,1 with inputs 011, 111, 100 → out_valid pattern 1,0,1; data 0/1 then 1/0 on the valid cycles.
- Asynchronous reset mid-stream, LATENCY=3:
  - Assert rst between edges with 2 samples in flight → outputs go to 0/0, out_valid=0 immediately, without waiting for an edge.
  - No stale sample appears after release.
- Reset release: apply 110 at the first edge after rst deasserts → 0/1 with out_valid=1 LATENCY edges later; nothing earlier.
- FULL_ADDER_CARRY_STATS_EN, CNT_W=2:
  - Six valid 111 samples → carry_count goes 1, 2, 3, 3, 3, 3 (saturates).
  - rst returns carry_count to 0.
